// File: rtl/mini_core_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package mini_core_pkg;

    localparam int unsigned FIFO_DEPTH_DEF   = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } t_rf_wr_entry;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_LONG = 2'd2
    } t_rf_gnt;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/mini_core_rf_wr_fifo.sv
// Long-latency result FIFO; exposes per-entry valid/rd taps so the arbiter
// can build the pending-destination mask from registered state only.
module mini_core_rf_wr_fifo
    import mini_core_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [4:0]           push_rd_i,
    input  logic [31:0]          push_data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [4:0]           head_rd_o,
    output logic [31:0]          head_data_o,
    output logic [DEPTH-1:0]     entry_valid_o,
    output logic [DEPTH*5-1:0]   entry_rd_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    count_q;
    logic [DEPTH-1:0] valid_q, valid_d;
    t_rf_wr_entry   mem_q [DEPTH];

    logic do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        valid_d = valid_q;
        if (do_pop)  valid_d[rd_ptr_q] = 1'b0;
        if (do_push) valid_d[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= '{rd: push_rd_i, data: push_data_i};
    end

    assign head_rd_o     = mem_q[rd_ptr_q].rd;
    assign head_data_o   = mem_q[rd_ptr_q].data;
    assign entry_valid_o = valid_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign entry_rd_o[gi*5 +: 5] = mem_q[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/mini_core_rf_wr_arb.sv
// Register-file write-port arbiter: pipeline write-back vs. queued
// long-latency results, with starvation bound and same-rd ordering stall.
module mini_core_rf_wr_arb
    import mini_core_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        WbValidQ104H,
    input  logic [4:0]  WbRdQ104H,
    input  logic [31:0] RegWrDataQ104H,
    input  logic        LongValid,
    input  logic [4:0]  LongRd,
    input  logic [31:0] LongData,
    output logic        LongReady,
    output logic        RfWrEn,
    output logic [4:0]  RfWrAddr,
    output logic [31:0] RfWrData,
    output logic        StallQ104H,
    output logic [31:0] PendingMask
);

    logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [4:0]              head_rd;
    logic [31:0]             head_data;
    logic [FIFO_DEPTH-1:0]   entry_valid;
    logic [FIFO_DEPTH*5-1:0] entry_rd;

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       starve, conflict, wb_ok;
    logic [31:0] pending_mask;
    t_rf_gnt    gnt;

    // rd=0 long results are acknowledged but never enter the FIFO.
    assign LongReady = ~fifo_full;
    assign fifo_push = LongValid & ~fifo_full & (LongRd != 5'd0);

    mini_core_rf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk           (Clock),
        .rst           (Rst),
        .push_i        (fifo_push),
        .push_rd_i     (LongRd),
        .push_data_i   (LongData),
        .pop_i         (fifo_pop),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_rd_o     (head_rd),
        .head_data_o   (head_data),
        .entry_valid_o (entry_valid),
        .entry_rd_o    (entry_rd)
    );

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (entry_valid[i]) pending_mask = pending_mask | rd_onehot(entry_rd[i*5 +: 5]);
        end
        pending_mask[0] = 1'b0;
    end
    assign PendingMask = pending_mask;

    assign wb_ok    = WbValidQ104H & (WbRdQ104H != 5'd0);
    assign conflict = WbValidQ104H & pending_mask[WbRdQ104H];
    assign starve   = (starve_cnt_q == 4'(STARVE_LIMIT));

    always_comb begin
        gnt        = GNT_NONE;
        StallQ104H = 1'b0;
        if (fifo_empty) begin
            if (wb_ok) gnt = GNT_PIPE;
        end else if (!wb_ok) begin
            gnt = GNT_LONG;
        end else if (!conflict && !starve) begin
            gnt = GNT_PIPE;
        end else begin
            gnt        = GNT_LONG;
            StallQ104H = 1'b1;
        end
    end

    assign fifo_pop = (gnt == GNT_LONG);

    always_comb begin
        RfWrEn   = 1'b0;
        RfWrAddr = 5'd0;
        RfWrData = 32'd0;
        case (gnt)
            GNT_PIPE: begin
                RfWrEn   = 1'b1;
                RfWrAddr = WbRdQ104H;
                RfWrData = RegWrDataQ104H;
            end
            GNT_LONG: begin
                RfWrEn   = 1'b1;
                RfWrAddr = head_rd;
                RfWrData = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || fifo_pop) starve_cnt_d = 4'd0;
        else if (!starve)           starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) starve_cnt_q <= 4'd0;
        else     starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: tb/tb_mini_core_rf_wr_arb.sv
// Directed bench for mini_core_rf_wr_arb: per-cycle vectors with
// hand-computed RF write / stall / ready / mask expectations.
module tb_mini_core_rf_wr_arb;

    logic        Clock = 1'b0;
    logic        Rst;
    logic        WbValidQ104H;
    logic [4:0]  WbRdQ104H;
    logic [31:0] RegWrDataQ104H;
    logic        LongValid;
    logic [4:0]  LongRd;
    logic [31:0] LongData;
    logic        LongReady, RfWrEn, StallQ104H;
    logic [4:0]  RfWrAddr;
    logic [31:0] RfWrData, PendingMask;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic [71:0] exp;
    } vec_t;

    mini_core_rf_wr_arb #(.FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
        .Clock          (Clock),
        .Rst            (Rst),
        .WbValidQ104H   (WbValidQ104H),
        .WbRdQ104H      (WbRdQ104H),
        .RegWrDataQ104H (RegWrDataQ104H),
        .LongValid      (LongValid),
        .LongRd         (LongRd),
        .LongData       (LongData),
        .LongReady      (LongReady),
        .RfWrEn         (RfWrEn),
        .RfWrAddr       (RfWrAddr),
        .RfWrData       (RfWrData),
        .StallQ104H     (StallQ104H),
        .PendingMask    (PendingMask)
    );

    always #5 Clock = ~Clock;

    wire [71:0] obs = {RfWrEn, RfWrAddr, RfWrData, StallQ104H, LongReady, PendingMask};

    function automatic vec_t mkv(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                 input logic en, input logic [4:0] addr, input logic [31:0] data,
                                 input logic stall, input logic rdy, input logic [31:0] mask);
        vec_t v;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.exp = {en, addr, data, stall, rdy, mask};
        return v;
    endfunction

    function automatic logic [31:0] bit_of(input int r);
        return 32'd1 << r;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        WbValidQ104H   = v.wbv;
        WbRdQ104H      = v.wbrd;
        RegWrDataQ104H = v.wbd;
        LongValid      = v.lv;
        LongRd         = v.lrd;
        LongData       = v.ld;
    endtask

    task automatic test_reset();
        vec_t v;
        Rst = 1'b1;
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0});
        end
        $display("reset_hold obs=%h", obs);
        step(); step();
        Rst = 1'b0;
        v = mkv(1, 5, 32'h1234, 0, 0, 0, 1, 5, 32'h1234, 0, 1, 0);
        drive(v);
        #1;
        checks++;
        if (obs !== v.exp) begin
            errors++;
            $display("FAIL reset_first_wb got=%h want=%h", obs, v.exp);
        end
        $display("reset_first_wb x5 en=%0b addr=%0d data=%h", RfWrEn, RfWrAddr, RfWrData);
        step();
        v = mkv(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(v);
        #1;
        checks++;
        if (obs !== v.exp) begin
            errors++;
            $display("FAIL x0_wb_suppressed got=%h want=%h", obs, v.exp);
        end
        $display("x0_wb en=%0b", RfWrEn);
        step();
    endtask

    task automatic test_long_idle();
        vec_t v[$];
        v.push_back(mkv(0, 0, 0, 1, 7, 32'hAAAA, 0, 0, 0, 0, 1, 0));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 7, 32'hAAAA, 0, 1, bit_of(7)));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].exp) begin
                errors++;
                $display("FAIL long_idle[%0d] got en=%0b a=%0d d=%h st=%0b rdy=%0b m=%h want=%h",
                         i, obs[71], obs[70:66], obs[65:34], obs[33], obs[32], obs[31:0], v[i].exp);
            end
            $display("long_idle[%0d] en=%0b a=%0d d=%h st=%0b m=%h", i, RfWrEn, RfWrAddr, RfWrData, StallQ104H, PendingMask);
            step();
        end
    endtask

    task automatic test_starve();
        vec_t v[$];
        v.push_back(mkv(1, 2, 32'h22, 1, 9, 32'h99, 1, 2, 32'h22, 0, 1, 0));
        v.push_back(mkv(1, 3, 32'h33, 0, 0, 0, 1, 3, 32'h33, 0, 1, bit_of(9)));
        v.push_back(mkv(1, 4, 32'h44, 0, 0, 0, 1, 4, 32'h44, 0, 1, bit_of(9)));
        v.push_back(mkv(1, 5, 32'h55, 0, 0, 0, 1, 5, 32'h55, 0, 1, bit_of(9)));
        v.push_back(mkv(1, 6, 32'h66, 0, 0, 0, 1, 6, 32'h66, 0, 1, bit_of(9)));
        v.push_back(mkv(1, 10, 32'hA0, 0, 0, 0, 1, 9, 32'h99, 1, 1, bit_of(9)));
        v.push_back(mkv(1, 10, 32'hA0, 0, 0, 0, 1, 10, 32'hA0, 0, 1, 0));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].exp) begin
                errors++;
                $display("FAIL starve[%0d] got en=%0b a=%0d d=%h st=%0b rdy=%0b m=%h want=%h",
                         i, obs[71], obs[70:66], obs[65:34], obs[33], obs[32], obs[31:0], v[i].exp);
            end
            $display("starve[%0d] en=%0b a=%0d d=%h st=%0b m=%h", i, RfWrEn, RfWrAddr, RfWrData, StallQ104H, PendingMask);
            step();
        end
    endtask

    task automatic test_conflict();
        vec_t v[$];
        v.push_back(mkv(1, 1, 32'h1, 1, 8, 32'h11, 1, 1, 32'h1, 0, 1, 0));
        v.push_back(mkv(1, 8, 32'h2, 0, 0, 0, 1, 8, 32'h11, 1, 1, bit_of(8)));
        v.push_back(mkv(1, 8, 32'h2, 0, 0, 0, 1, 8, 32'h2, 0, 1, 0));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].exp) begin
                errors++;
                $display("FAIL conflict[%0d] got en=%0b a=%0d d=%h st=%0b rdy=%0b m=%h want=%h",
                         i, obs[71], obs[70:66], obs[65:34], obs[33], obs[32], obs[31:0], v[i].exp);
            end
            $display("conflict[%0d] en=%0b a=%0d d=%h st=%0b m=%h", i, RfWrEn, RfWrAddr, RfWrData, StallQ104H, PendingMask);
            step();
        end
    endtask

    task automatic test_fill();
        vec_t v[$];
        logic [31:0] m20_23 = bit_of(20) | bit_of(21) | bit_of(22) | bit_of(23);
        v.push_back(mkv(1, 1, 32'h100, 1, 20, 32'h2000, 1, 1, 32'h100, 0, 1, 0));
        v.push_back(mkv(1, 1, 32'h101, 1, 21, 32'h2100, 1, 1, 32'h101, 0, 1, bit_of(20)));
        v.push_back(mkv(1, 1, 32'h102, 1, 22, 32'h2200, 1, 1, 32'h102, 0, 1, bit_of(20) | bit_of(21)));
        v.push_back(mkv(1, 1, 32'h103, 1, 23, 32'h2300, 1, 1, 32'h103, 0, 1, m20_23 & ~bit_of(23)));
        v.push_back(mkv(1, 1, 32'h104, 1, 24, 32'h2400, 1, 1, 32'h104, 0, 0, m20_23));
        v.push_back(mkv(1, 1, 32'h105, 1, 24, 32'h2400, 1, 20, 32'h2000, 1, 0, m20_23));
        v.push_back(mkv(1, 1, 32'h105, 1, 0, 32'hDEAD, 1, 1, 32'h105, 0, 1, m20_23 & ~bit_of(20)));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 21, 32'h2100, 0, 1, m20_23 & ~bit_of(20)));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 22, 32'h2200, 0, 1, bit_of(22) | bit_of(23)));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 23, 32'h2300, 0, 1, bit_of(23)));
        v.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].exp) begin
                errors++;
                $display("FAIL fill[%0d] got en=%0b a=%0d d=%h st=%0b rdy=%0b m=%h want=%h",
                         i, obs[71], obs[70:66], obs[65:34], obs[33], obs[32], obs[31:0], v[i].exp);
            end
            $display("fill[%0d] en=%0b a=%0d d=%h st=%0b rdy=%0b m=%h", i, RfWrEn, RfWrAddr, RfWrData, StallQ104H, LongReady, PendingMask);
            step();
        end
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        v.push_back(mkv(1, 1, 32'h1, 1, 25, 32'h25, 1, 1, 32'h1, 0, 1, 0));
        v.push_back(mkv(1, 1, 32'h2, 1, 26, 32'h26, 1, 1, 32'h2, 0, 1, bit_of(25)));
        v.push_back(mkv(1, 1, 32'h3, 1, 27, 32'h27, 1, 1, 32'h3, 0, 1, bit_of(25) | bit_of(26)));
        foreach (v[i]) begin
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].exp) begin
                errors++;
                $display("FAIL reset_mid_fill[%0d] got=%h want=%h", i, obs, v[i].exp);
            end
            $display("reset_mid_fill[%0d] m=%h", i, PendingMask);
            step();
        end
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if (PendingMask !== (bit_of(25) | bit_of(26) | bit_of(27))) begin
            errors++;
            $display("FAIL reset_mid_queued mask got=%h want=%h", PendingMask, bit_of(25) | bit_of(26) | bit_of(27));
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_async got=%h want=%h", obs, {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0});
        end
        $display("reset_mid_async m=%h rdy=%0b en=%0b", PendingMask, LongReady, RfWrEn);
        step(); step();
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0}) begin
                errors++;
                $display("FAIL reset_mid_after[%0d] got=%h want=%h", i, obs, {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0});
            end
            $display("reset_mid_after[%0d] en=%0b m=%h", i, RfWrEn, PendingMask);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_long_idle();
        test_starve();
        test_conflict();
        test_fill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mini_core_rf_wr_arb.md
# mini_core_rf_wr_arb

Register-file write-port arbiter between the in-order pipeline write-back (Q104H) and a long-latency writer (divider / delayed load return) that completes out of band. Holds long-latency results in a small FIFO, drains them into free write slots, and stalls the pipeline when the FIFO starves or when program order demands it. Publishes a pending-destination mask for the hazard unit. Sits between `mini_core_wb` and the register file write port.

## Interface
- `FIFO_DEPTH`, 4, long-result FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive denied cycles before the FIFO is forced through (1..15)

- `Clock`  in  1  core clock
- `Rst`  in  1  asynchronous, active-high reset
- `WbValidQ104H`  in  1  pipeline has a register write this cycle
- `WbRdQ104H`  in  5  pipeline destination register
- `RegWrDataQ104H`  in  32  pipeline write data
- `LongValid`  in  1  long-latency result offered
- `LongRd`  in  5  long-latency destination
- `LongData`  in  32  long-latency result
- `LongReady`  out  1  FIFO accepts; push = `LongValid & LongReady`
- `RfWrEn`  out  1  register-file write enable
- `RfWrAddr`  out  5  register-file write address
- `RfWrData`  out  32  register-file write data
- `StallQ104H`  out  1  pipeline must hold Q104H and everything upstream this cycle
- `PendingMask`  out  32  bit r set while a FIFO entry targets x r (bit 0 always 0)

## Operation
- FIFO: registered entries {rd, data}; no push-to-pop bypass. `LongReady = !full`, independent of a pop in the same cycle.
- Writes to x0 from either source are never issued to the RF; a long result with rd=0 is accepted and discarded without entering the FIFO.
- `PendingMask` = OR of decoded rd over valid FIFO entries (registered state only).
- Conflict = `WbValidQ104H & PendingMask[WbRdQ104H]` (older long write to the same rd must land first).
- Starvation counter `StarveCnt`: 0 when FIFO empty or on a pop; else +1 per cycle, saturating at `STARVE_LIMIT`. `Starve = (StarveCnt == STARVE_LIMIT)`.
- Grant per cycle:
  - FIFO empty: pipeline write (if valid and rd≠0), no stall.
  - FIFO non-empty, `!WbValidQ104H` (or pipeline rd=0): pop FIFO head into RF.
  - FIFO non-empty, pipeline valid, no conflict, `!Starve`: pipeline writes, FIFO waits.
  - FIFO non-empty, pipeline valid, conflict or `Starve`: pop FIFO head, `StallQ104H=1`; pipeline write suppressed and re-presented next cycle by the held stage.
- `StallQ104H` is asserted only when a pipeline write is valid and denied.
- Pop and push in the same cycle allowed when not full; count unchanged.

## Timing
- Reset: FIFO empty, pointers 0, `StarveCnt`=0. After reset: `LongReady`=1, `PendingMask`=0, `StallQ104H`=0, `RfWrEn`=`WbValidQ104H & (WbRdQ104H≠0)`.
- Reset mid-operation discards all FIFO contents immediately (asynchronous).
- `RfWrEn/Addr/Data` and `StallQ104H` are combinational from inputs and registered state, same cycle.
- Push in cycle N: entry visible (mask bit, eligible to pop) from N+1; earliest RF write N+1.
- Same-cycle long push vs pipeline rd equality is not checked; hazard unit owns that case.
- Worst-case pipeline write delay with no conflict: 1 stall cycle per `STARVE_LIMIT`+1 cycles while FIFO is non-empty.
- Conflict drain: stall continues until the matching mask bit clears (up to `FIFO_DEPTH` cycles).

## Structure
- `mini_core_pkg`: `t_rf_wr_entry` struct {rd[4:0], data[31:0]}; defaults for `FIFO_DEPTH`/`STARVE_LIMIT`.
- Sub-module `mini_core_rf_wr_fifo`: parameterized FIFO with full/empty and per-entry valid/rd taps for the mask. Arbitration, counter and mask logic in the top.

## Test plan
- Reset, idle long side; pipeline writes x5=0x1234 -> RfWrEn=1, addr 5, data 0x1234, no stall; `LongReady`=1, mask 0.
- Push x7=0xAAAA in cycle N with pipeline idle -> mask bit 7 set at N+1, RF write x7=0xAAAA at N+1, mask 0 at N+2.
- FIFO holds x9, pipeline writes x3,x4,x5,x6 back-to-back (STARVE_LIMIT=4) -> pipeline wins 4 cycles, 5th cycle pops x9 with `StallQ104H`=1, held pipeline write lands the next cycle.
- FIFO holds x8; pipeline writes x8=0x2 -> stall 1 cycle, long x8 written first, pipeline x8=0x2 next; final x8=0x2.
- Fill 4 entries with pipeline continuously writing under no conflict -> `LongReady`=0 when full; push on a pop cycle refused; a long push with rd=0 accepted, never written, mask unchanged.
- Assert `Rst` with 3 entries queued -> mask 0, `LongReady`=1, no RF write of discarded entries after release.
